// File: rtl/tap_pkg.sv
// Shared TAP definitions: 1149.1 state codes as seen on state_obs_Pad, the state
// enum built on them, and the data-register select enum.
package tap_pkg;

  localparam logic [3:0] ST_EX2DR   = 4'h0;
  localparam logic [3:0] ST_EX1DR   = 4'h1;
  localparam logic [3:0] ST_SHDR    = 4'h2;
  localparam logic [3:0] ST_PAUSEDR = 4'h3;
  localparam logic [3:0] ST_SELIR   = 4'h4;
  localparam logic [3:0] ST_UPDDR   = 4'h5;
  localparam logic [3:0] ST_CAPDR   = 4'h6;
  localparam logic [3:0] ST_SELDR   = 4'h7;
  localparam logic [3:0] ST_EX2IR   = 4'h8;
  localparam logic [3:0] ST_EX1IR   = 4'h9;
  localparam logic [3:0] ST_SHIR    = 4'hA;
  localparam logic [3:0] ST_PAUSEIR = 4'hB;
  localparam logic [3:0] ST_RTI     = 4'hC;
  localparam logic [3:0] ST_UPDIR   = 4'hD;
  localparam logic [3:0] ST_CAPIR   = 4'hE;
  localparam logic [3:0] ST_TLR     = 4'hF;

  typedef enum logic [3:0] {
    S_EX2DR   = ST_EX2DR,
    S_EX1DR   = ST_EX1DR,
    S_SHDR    = ST_SHDR,
    S_PAUSEDR = ST_PAUSEDR,
    S_SELIR   = ST_SELIR,
    S_UPDDR   = ST_UPDDR,
    S_CAPDR   = ST_CAPDR,
    S_SELDR   = ST_SELDR,
    S_EX2IR   = ST_EX2IR,
    S_EX1IR   = ST_EX1IR,
    S_SHIR    = ST_SHIR,
    S_PAUSEIR = ST_PAUSEIR,
    S_RTI     = ST_RTI,
    S_UPDIR   = ST_UPDIR,
    S_CAPIR   = ST_CAPIR,
    S_TLR     = ST_TLR
  } state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_e;

endpackage

// File: rtl/tap_fsm.sv
// 16-state 1149.1 TAP controller. Strobes mark the state whose exit edge performs
// the action; tlr flags the edge on which the controller enters Test-Logic-Reset.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       GCLK_Pad,
  input  logic       TRST_Pad,
  input  logic       TMS_Pad,
  output logic [3:0] state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       tlr
);

  state_t state_q, state_d;

  always_comb begin
    // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_TLR:     state_d = TMS_Pad ? S_TLR     : S_RTI;
      S_RTI:     state_d = TMS_Pad ? S_SELDR   : S_RTI;
      S_SELDR:   state_d = TMS_Pad ? S_SELIR   : S_CAPDR;
      S_CAPDR:   state_d = TMS_Pad ? S_EX1DR   : S_SHDR;
      S_SHDR:    state_d = TMS_Pad ? S_EX1DR   : S_SHDR;
      S_EX1DR:   state_d = TMS_Pad ? S_UPDDR   : S_PAUSEDR;
      S_PAUSEDR: state_d = TMS_Pad ? S_EX2DR   : S_PAUSEDR;
      S_EX2DR:   state_d = TMS_Pad ? S_UPDDR   : S_SHDR;
      S_UPDDR:   state_d = TMS_Pad ? S_SELDR   : S_RTI;
      S_SELIR:   state_d = TMS_Pad ? S_TLR     : S_CAPIR;
      S_CAPIR:   state_d = TMS_Pad ? S_EX1IR   : S_SHIR;
      S_SHIR:    state_d = TMS_Pad ? S_EX1IR   : S_SHIR;
      S_EX1IR:   state_d = TMS_Pad ? S_UPDIR   : S_PAUSEIR;
      S_PAUSEIR: state_d = TMS_Pad ? S_EX2IR   : S_PAUSEIR;
      S_EX2IR:   state_d = TMS_Pad ? S_UPDIR   : S_SHIR;
      S_UPDIR:   state_d = TMS_Pad ? S_SELDR   : S_RTI;
    endcase
  end

  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    // NOTE: non-blocking in clocked blocks so every flop samples pre-edge values.
    if (TRST_Pad) state_q <= S_TLR;
    else          state_q <= state_d;
  end

  assign state      = state_q;
  assign capture_dr = (state_q == S_CAPDR);
  assign shift_dr   = (state_q == S_SHDR);
  assign update_dr  = (state_q == S_UPDDR);
  assign capture_ir = (state_q == S_CAPIR);
  assign shift_ir   = (state_q == S_SHIR);
  assign update_ir  = (state_q == S_UPDIR);
  assign tlr        = (state_d == S_TLR);

endmodule

// File: rtl/tap_ctrl_param.sv
// Parametrised TAP: instruction register, BYPASS/IDCODE/USER data registers and TDO mux.
// Build macro TAP_IDCODE_EN adds the 32-bit IDCODE register; without it IR resets to BYPASS.
module tap_ctrl_param
  import tap_pkg::*;
#(
  parameter int                  IR_WIDTH      = 4,
  parameter int                  USER_DR_WIDTH = 8,
  parameter logic [31:0]         IDCODE_VAL    = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE     = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_USER       = IR_WIDTH'(2)
) (
  input  logic                     GCLK_Pad,
  input  logic                     TRST_Pad,
  input  logic                     TMS_Pad,
  input  logic                     TDI_Pad,
  output logic                     TDO_Pad,
  output logic                     TDO_EN_Pad,
  output logic [3:0]               state_obs_Pad,
  output logic [IR_WIDTH-1:0]      ir_out,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_update
);

  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_BYPASS;
  localparam logic                unused_idcode_params = ^{IDCODE_VAL, OP_IDCODE};
`endif

  logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, tlr;

  tap_fsm u_fsm (
    .GCLK_Pad   (GCLK_Pad),
    .TRST_Pad   (TRST_Pad),
    .TMS_Pad    (TMS_Pad),
    .state      (state_obs_Pad),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .tlr        (tlr)
  );

  logic [IR_WIDTH-1:0]      ir_sr_q, ir_sr_d, ir_out_q, ir_out_d;
  logic                     bypass_q, bypass_d;
  logic [USER_DR_WIDTH-1:0] user_sr_q, user_sr_d, user_dr_out_q, user_dr_out_d;
  logic                     user_update_q, user_update_d;
`ifdef TAP_IDCODE_EN
  logic [31:0]              idcode_sr_q, idcode_sr_d;
`endif
  dr_sel_e                  dr_sel;
  logic                     tdo_dr;

  // ir_out only moves in UpdIR/TLR, so the selection is stable for a whole DR scan.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_out_q == IR_BYPASS)    dr_sel = DR_BYPASS;
`ifdef TAP_IDCODE_EN
    else if (ir_out_q == OP_IDCODE) dr_sel = DR_IDCODE;
`endif
    else if (ir_out_q == OP_USER) dr_sel = DR_USER;
  end

  always_comb begin
    ir_sr_d       = ir_sr_q;
    ir_out_d      = ir_out_q;
    bypass_d      = bypass_q;
    user_sr_d     = user_sr_q;
    user_dr_out_d = user_dr_out_q;
    user_update_d = 1'b0;
`ifdef TAP_IDCODE_EN
    idcode_sr_d   = idcode_sr_q;
`endif

    if (capture_ir)    ir_sr_d = IR_CAPTURE;
    else if (shift_ir) ir_sr_d = {TDI_Pad, ir_sr_q[IR_WIDTH-1:1]};

    if (tlr)            ir_out_d = IR_RESET;
    else if (update_ir) ir_out_d = ir_sr_q;

    // Shifts take the low bits of {TDI, reg} >> 1 so a 1-bit USER register still works.
    if (capture_dr) begin
      unique case (dr_sel)
        DR_USER:   user_sr_d   = user_dr_in;
`ifdef TAP_IDCODE_EN
        DR_IDCODE: idcode_sr_d = IDCODE_VAL;
`endif
        default:   bypass_d    = 1'b0;
      endcase
    end else if (shift_dr) begin
      unique case (dr_sel)
        DR_USER:   user_sr_d   = USER_DR_WIDTH'({TDI_Pad, user_sr_q} >> 1);
`ifdef TAP_IDCODE_EN
        DR_IDCODE: idcode_sr_d = 32'({TDI_Pad, idcode_sr_q} >> 1);
`endif
        default:   bypass_d    = TDI_Pad;
      endcase
    end

    if (update_dr && dr_sel == DR_USER) begin
      user_dr_out_d = user_sr_q;
      user_update_d = 1'b1;
    end
  end

  always_ff @(posedge GCLK_Pad or posedge TRST_Pad) begin
    if (TRST_Pad) begin
      // NOTE: shift registers are reset too, so TDO is deterministic after any reset.
      ir_sr_q       <= '0;
      ir_out_q      <= IR_RESET;
      bypass_q      <= 1'b0;
      user_sr_q     <= '0;
      user_dr_out_q <= '0;
      user_update_q <= 1'b0;
`ifdef TAP_IDCODE_EN
      idcode_sr_q   <= '0;
`endif
    end else begin
      ir_sr_q       <= ir_sr_d;
      ir_out_q      <= ir_out_d;
      bypass_q      <= bypass_d;
      user_sr_q     <= user_sr_d;
      user_dr_out_q <= user_dr_out_d;
      user_update_q <= user_update_d;
`ifdef TAP_IDCODE_EN
      idcode_sr_q   <= idcode_sr_d;
`endif
    end
  end

  always_comb begin
    unique case (dr_sel)
      DR_USER:   tdo_dr = user_sr_q[0];
`ifdef TAP_IDCODE_EN
      DR_IDCODE: tdo_dr = idcode_sr_q[0];
`endif
      default:   tdo_dr = bypass_q;
    endcase
  end

  assign TDO_EN_Pad  = shift_ir | shift_dr;
  assign TDO_Pad     = shift_ir ? ir_sr_q[0] : (shift_dr ? tdo_dr : 1'b0);
  assign ir_out      = ir_out_q;
  assign user_dr_out = user_dr_out_q;
  assign user_update = user_update_q;

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Self-checking bench for tap_ctrl_param: a bit-queue model of the TAP checked every
// cycle, plus directed scans with hand-computed expectations.
module tb_tap_ctrl_param;

  localparam int          IRW = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam bit IDC_EN = 1'b1;
`else
  localparam bit IDC_EN = 1'b0;
`endif
  localparam logic [3:0] IR_RST = IDC_EN ? 4'h1 : 4'hF;

  logic       clk = 1'b0, trst = 1'b1, tms = 1'b1, tdi = 1'b0;
  logic       tdo, tdo_en, uupd;
  logic [3:0] st, ir_out;
  logic [7:0] udin = 8'h00, udout;

  always #5 clk = ~clk;

  tap_ctrl_param dut (
    .GCLK_Pad      (clk),
    .TRST_Pad      (trst),
    .TMS_Pad       (tms),
    .TDI_Pad       (tdi),
    .TDO_Pad       (tdo),
    .TDO_EN_Pad    (tdo_en),
    .state_obs_Pad (st),
    .ir_out        (ir_out),
    .user_dr_in    (udin),
    .user_dr_out   (udout),
    .user_update   (uupd)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 1149.1 state graph as lookup tables indexed by state code.
  logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  logic [3:0] m_state, m_ir_out;
  logic [7:0] m_uout;
  bit         m_upd;
  bit         m_ir_q [$];
  bit         m_dr   [$];

  function automatic int sel_of(input logic [3:0] ir);
    if (ir == 4'hF) return 0;
    if (IDC_EN && ir == 4'h1) return 1;
    if (ir == 4'h2) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_state  = 4'hF;
    m_ir_out = IR_RST;
    m_uout   = 8'h00;
    m_upd    = 1'b0;
    m_ir_q.delete();
    for (int i = 0; i < IRW; i++) m_ir_q.push_back(1'b0);
    m_dr.delete();
    m_dr.push_back(1'b0);
  endtask

  task automatic model_step(input bit t, input bit d, input logic [7:0] uin);
    logic [3:0] s;
    s     = m_state;
    m_upd = 1'b0;
    if (s == 4'hE) begin
      m_ir_q.delete();
      for (int i = 0; i < IRW; i++) m_ir_q.push_back(i == 0);
    end else if (s == 4'hA) begin
      void'(m_ir_q.pop_front());
      m_ir_q.push_back(d);
    end else if (s == 4'hD) begin
      for (int i = 0; i < IRW; i++) m_ir_out[i] = m_ir_q[i];
    end else if (s == 4'h6) begin
      m_dr.delete();
      case (sel_of(m_ir_out))
        1:       for (int i = 0; i < 32; i++) m_dr.push_back(IDV[i]);
        2:       for (int i = 0; i < 8; i++)  m_dr.push_back(uin[i]);
        default: m_dr.push_back(1'b0);
      endcase
    end else if (s == 4'h2) begin
      void'(m_dr.pop_front());
      m_dr.push_back(d);
    end else if (s == 4'h5 && sel_of(m_ir_out) == 2) begin
      for (int i = 0; i < 8; i++) m_uout[i] = m_dr[i];
      m_upd = 1'b1;
    end
    m_state = t ? nxt1[s] : nxt0[s];
    if (m_state == 4'hF) m_ir_out = IR_RST;
  endtask

  always @(posedge clk) begin
    if (trst) model_reset();
    else      model_step(tms, tdi, udin);
  end

  always @(negedge clk) begin
    if (cmp_en && !trst) begin
      check("state",       st,     m_state);
      check("ir_out",      ir_out, m_ir_out);
      check("tdo_en",      tdo_en, (m_state == 4'h2 || m_state == 4'hA));
      check("tdo",         tdo,    (m_state == 4'hA) ? m_ir_q[0] :
                                   (m_state == 4'h2) ? m_dr[0] : 1'b0);
      check("user_dr_out", udout,  m_uout);
      check("user_update", uupd,   m_upd);
    end
  end

  task automatic tick(input bit t, input bit d);
    tms = t;
    tdi = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic shift(input int n, input logic [31:0] din, input bit exit_last,
                       output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tick(exit_last && (i == n - 1), din[i]);
    end
  endtask

  task automatic goto_shdr();  // from RTI
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic finish_scan();  // from Exit1 back to RTI
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [31:0] cap);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift(IRW, {28'h0, v}, 1'b1, cap);
    finish_scan();
  endtask

  initial begin
    logic [31:0] dout, dout2, rnd;
    logic [7:0]  ucap;

    model_reset();
    repeat (3) @(negedge clk);
    trst   = 1'b0;
    cmp_en = 1'b1;
    check("rst_state",  st,     4'hF);
    check("rst_ir_out", ir_out, IR_RST);
    check("rst_tdo_en", tdo_en, 1'b0);
    check("rst_udout",  udout,  8'h00);

    // TMS walk 0,1,0,0 then five ones.
    tick(1'b0, 1'b0); check("walk_rti",   st, 4'hC);
    tick(1'b1, 1'b0); check("walk_seldr", st, 4'h7);
    tick(1'b0, 1'b0); check("walk_capdr", st, 4'h6);
    tick(1'b0, 1'b0); check("walk_shdr",  st, 4'h2);
    repeat (5) tick(1'b1, 1'b0);
    check("walk_tlr", st, 4'hF);

    // DR scan with the reset instruction.
    tick(1'b0, 1'b0);
    goto_shdr();
    rnd = $urandom;
    shift(32, rnd, 1'b1, dout);
    check("idcode_scan", dout, IDC_EN ? IDV : {rnd[30:0], 1'b0});
    finish_scan();

    // IR capture pattern and BYPASS.
    load_ir(4'hF, dout);
    check("ir_capture", dout[3:0], 4'b0001);
    check("ir_bypass",  ir_out,    4'hF);
    goto_shdr();
    shift(4, 32'b1101, 1'b1, dout);
    check("bypass_tdo", dout[3:0], 4'b1010);
    finish_scan();

    // USER capture, shift and update pulse.
    load_ir(4'h2, dout);
    check("ir_user", ir_out, 4'h2);
    udin = 8'hA5;
    goto_shdr();
    shift(8, 32'h3C, 1'b1, dout);
    check("user_tdo", dout[7:0], 8'hA5);
    tick(1'b1, 1'b0);
    check("upd_before", uupd, 1'b0);
    tick(1'b0, 1'b0);
    check("upd_pulse", uupd,  1'b1);
    check("upd_value", udout, 8'h3C);
    tick(1'b0, 1'b0);
    check("upd_after", uupd,  1'b0);
    check("upd_hold",  udout, 8'h3C);

    // Pause in the middle of a USER scan.
    udin = 8'($urandom);
    ucap = udin;
    rnd  = $urandom;
    goto_shdr();
    shift(4, {28'h0, rnd[3:0]}, 1'b1, dout);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("pause_back_shdr", st, 4'h2);
    shift(4, {28'h0, rnd[7:4]}, 1'b1, dout2);
    check("pause_tdo", {dout2[3:0], dout[3:0]}, ucap);
    finish_scan();
    check("pause_udout", udout, rnd[7:0]);

    // Asynchronous reset between edges while in Shift-DR.
    goto_shdr();
    tick(1'b0, 1'b1);
    @(posedge clk);
    #2 trst = 1'b1;
    #1;
    check("async_state",  st,     4'hF);
    check("async_ir_out", ir_out, IR_RST);
    check("async_tdo_en", tdo_en, 1'b0);
    check("async_udout",  udout,  8'h00);
    model_reset();
    #1 trst = 1'b0;
    @(negedge clk);

    // Random TMS/TDI traffic against the model.
    repeat (3000) begin
      if ($urandom_range(7, 0) == 0) udin = 8'($urandom);
      tick($urandom_range(3, 0) == 0, 1'($urandom_range(1, 0)));
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
